tm1637_display_ctrl: RTL and testbench

- Frame sequencer for the TM1637 4-digit LED driver.
- On a request, it snapshots a segment buffer, brightness and on/off state, then emits the complete TM1637 write transaction: data command, address plus digits, display control.
- It drives the two-wire bus directly via a tick-paced bit engine, so the ROM step machine no longer has to hand-sequence bytes.
- It sits between application logic (counter/clock display) and the tm1637_clk/tm1637_dio pins.

---
 rtl/tm1637_pkg.sv | 29 ++
 rtl/tm1637_bit_engine.sv | 146 ++++++++++++++
 rtl/tm1637_display_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tm1637_display_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// Shared definitions for the TM1637 frame sequencer and its bus bit engine.
// Contents: bit-engine op encodings, TM1637 command bytes, controller state
// enum and a helper that builds the display-control command byte.
package tm1637_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_BYTE  = 2'd1,
    OP_STOP  = 2'd2
  } op_e;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_CTRL      = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_FINISH
  } state_e;

  // Display control: bit 3 enables the display, bits 2:0 select pulse width.
  function automatic logic [7:0] ctrl_byte(input logic on, input logic [2:0] bright);
    return CMD_CTRL | {4'b0000, on, bright};
  endfunction

endpackage

// File: rtl/tm1637_bit_engine.sv
// Tick-paced TM1637 two-wire bit engine.
// Executes one START, BYTE (8 data bits LSB first plus ACK) or STOP op at a
// time, advancing exactly one step per prescaler tick.
// Ports:
//   clk_50M, rst_n   clock, async active-low reset
//   run              prescaler enable (frame in progress)
//   op_valid/op/op_byte  requested op; accepted on a tick while op_ready
//   op_ready         engine is between ops
//   op_done          combinational, high on the tick that finishes an op
//   ack_bit          synchronised DIO level, valid with op_done of a BYTE
//   bus_clk          TM1637 CLK pin
//   bus_dio_oe       1 = pull DIO low
//   dio_in           raw DIO pin readback
module tm1637_bit_engine
  import tm1637_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       run,
  input  logic       op_valid,
  input  logic [1:0] op,
  input  logic [7:0] op_byte,
  output logic       op_ready,
  output logic       op_done,
  output logic       ack_bit,
  output logic       bus_clk,
  output logic       bus_dio_oe,
  input  logic       dio_in
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;
  logic          tick;
  logic          sync1, sync2;
  logic          active;
  op_e           op_r;
  logic [7:0]    byte_r;
  logic [4:0]    step;

  op_e        cur_op;
  logic [7:0] cur_byte;
  logic [4:0] cur_step;
  logic       last_step;
  logic       clk_nx, oe_nx;
  logic       fire;

  assign tick = run && (count == CNT_LAST);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (!run || tick) count <= '0;
    else count <= count + 1'b1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= dio_in;
      sync2 <= sync1;
    end
  end

  // While idle the first step of a newly offered op is executed on the very
  // tick that accepts it, so consecutive ops run on consecutive ticks.
  always_comb begin
    cur_op    = active ? op_r : op_e'(op);
    cur_byte  = active ? byte_r : op_byte;
    cur_step  = active ? step : 5'd0;
    clk_nx    = bus_clk;
    oe_nx     = bus_dio_oe;
    last_step = 1'b0;
    case (cur_op)
      OP_START: begin
        if (cur_step == 5'd0) begin
          oe_nx = 1'b1;
        end else begin
          clk_nx    = 1'b0;
          last_step = 1'b1;
        end
      end
      OP_BYTE: begin
        // Even steps drop CLK and set DIO; odd steps raise CLK. Steps 16/17
        // are the ACK slot with DIO released.
        if (!cur_step[0]) begin
          clk_nx = 1'b0;
          oe_nx  = (cur_step < 5'd16) ? ~cur_byte[cur_step[3:1]] : 1'b0;
        end else begin
          clk_nx    = 1'b1;
          last_step = (cur_step == 5'd17);
        end
      end
      OP_STOP: begin
        case (cur_step)
          5'd0: begin
            clk_nx = 1'b0;
            oe_nx  = 1'b1;
          end
          5'd1: clk_nx = 1'b1;
          default: begin
            oe_nx     = 1'b0;
            last_step = 1'b1;
          end
        endcase
      end
      default: last_step = 1'b1;
    endcase
  end

  assign fire     = tick && (active || op_valid);
  assign op_done  = fire && last_step;
  assign op_ready = !active;
  assign ack_bit  = sync2;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      op_r       <= OP_START;
      byte_r     <= 8'h00;
      step       <= 5'd0;
      bus_clk    <= 1'b1;
      bus_dio_oe <= 1'b0;
    end else if (!run) begin
      active <= 1'b0;
      step   <= 5'd0;
    end else if (fire) begin
      bus_clk    <= clk_nx;
      bus_dio_oe <= oe_nx;
      if (last_step) begin
        active <= 1'b0;
        step   <= 5'd0;
      end else begin
        active <= 1'b1;
        step   <= cur_step + 5'd1;
        op_r   <= cur_op;
        byte_r <= cur_byte;
      end
    end
  end

endmodule

// File: rtl/tm1637_display_ctrl.sv
// TM1637 4-digit LED frame sequencer.
// On update it snapshots the segment bytes, brightness and on/off state and
// sends: START 0x40 STOP, START 0xC0 digit0..digitN-1 STOP,
// START (0x80|on<<3|brightness) STOP, through tm1637_bit_engine.
// Ports:
//   clk_50M, rst_n       clock, async active-low reset
//   update               one-cycle frame request (merged into one pending
//                        request while busy)
//   digits               segment bytes, digit 0 in [7:0]
//   brightness, display_on  control byte fields
//   busy, done, ack_err  frame status; ack_err = some ACK sampled high
//   tm1637_clk           bus clock (push-pull)
//   tm1637_dio_oe        1 = pull DIO low
//   tm1637_dio_in        DIO pin readback
module tm1637_display_ctrl
  import tm1637_pkg::*;
#(
  parameter int CLK_DIV    = 250,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic                    update,
  input  logic [8*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    busy,
  output logic                    done,
  output logic                    ack_err,
  output logic                    tm1637_clk,
  output logic                    tm1637_dio_oe,
  input  logic                    tm1637_dio_in
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(NUM_DIGITS);

  state_e state, state_nx;
  logic [1:0] seg, seg_nx;
  logic [2:0] idx, idx_nx;
  logic [2:0] last_idx;
  logic       pending, pending_nx;
  logic       ack_acc, ack_acc_nx;
  logic       done_nx, ack_err_nx;
  logic       latch;

  logic [8*NUM_DIGITS-1:0] digits_lat;
  logic [2:0]              bright_lat;
  logic                    on_lat;

  logic       op_valid, op_ready, op_done, ack_bit;
  logic [1:0] op;
  logic [7:0] op_byte;

  assign busy = (state != ST_IDLE);

  tm1637_bit_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .run       (busy),
    .op_valid  (op_valid),
    .op        (op),
    .op_byte   (op_byte),
    .op_ready  (op_ready),
    .op_done   (op_done),
    .ack_bit   (ack_bit),
    .bus_clk   (tm1637_clk),
    .bus_dio_oe(tm1637_dio_oe),
    .dio_in    (tm1637_dio_in)
  );

  // Segment 1 carries the address byte followed by the digits; the other
  // segments are a single command byte.
  always_comb begin
    op_byte  = CMD_DATA_AUTO;
    last_idx = 3'd0;
    case (seg)
      2'd0: op_byte = CMD_DATA_AUTO;
      2'd1: begin
        last_idx = LAST_DATA_IDX;
        op_byte  = CMD_ADDR0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx == 3'(i + 1)) op_byte = digits_lat[8*i +: 8];
        end
      end
      default: op_byte = ctrl_byte(on_lat, bright_lat);
    endcase
  end

  always_comb begin
    state_nx   = state;
    seg_nx     = seg;
    idx_nx     = idx;
    ack_acc_nx = ack_acc;
    done_nx    = 1'b0;
    ack_err_nx = ack_err;
    pending_nx = pending | (update && (state != ST_IDLE));
    latch      = 1'b0;
    op_valid   = 1'b0;
    op         = OP_START;
    case (state)
      ST_IDLE: begin
        if (update) begin
          latch      = 1'b1;
          seg_nx     = 2'd0;
          ack_acc_nx = 1'b0;
          state_nx   = ST_START;
        end
      end
      ST_START: begin
        op_valid = 1'b1;
        op       = OP_START;
        if (op_done) begin
          idx_nx   = 3'd0;
          state_nx = ST_BYTE;
        end
      end
      ST_BYTE: begin
        op_valid = 1'b1;
        op       = OP_BYTE;
        if (op_done) begin
          ack_acc_nx = ack_acc | ack_bit;
          if (idx == last_idx) state_nx = ST_STOP;
          else idx_nx = idx + 3'd1;
        end
      end
      ST_STOP: begin
        op_valid = 1'b1;
        op       = OP_STOP;
        if (op_done) begin
          if (seg == 2'd2) begin
            state_nx = ST_FINISH;
          end else begin
            seg_nx   = seg + 2'd1;
            state_nx = ST_START;
          end
        end
      end
      ST_FINISH: begin
        // A merged pending request restarts directly, keeping busy high,
        // and samples the inputs present now rather than at request time.
        if (op_ready) begin
          done_nx    = 1'b1;
          ack_err_nx = ack_acc;
          pending_nx = 1'b0;
          if (pending || update) begin
            latch      = 1'b1;
            seg_nx     = 2'd0;
            ack_acc_nx = 1'b0;
            state_nx   = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      seg     <= 2'd0;
      idx     <= 3'd0;
      pending <= 1'b0;
      ack_acc <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nx;
      seg     <= seg_nx;
      idx     <= idx_nx;
      pending <= pending_nx;
      ack_acc <= ack_acc_nx;
      done    <= done_nx;
      ack_err <= ack_err_nx;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      digits_lat <= '0;
      bright_lat <= 3'd0;
      on_lat     <= 1'b0;
    end else if (latch) begin
      digits_lat <= digits;
      bright_lat <= brightness;
      on_lat     <= display_on;
    end
  end

endmodule

// File: tb/tb_tm1637_display_ctrl.sv
// Bench for tm1637_display_ctrl: instance A (CLK_DIV=4, 4 digits) and
// instance B (CLK_DIV=2, 1 digit), each with a TM1637 device model that
// decodes the bus into bytes and drives ACKs.
module tb_tm1637_display_ctrl;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        update_a, update_b;
  logic [31:0] digits_a;
  logic [7:0]  digits_b;
  logic [2:0]  brightness;
  logic        display_on;
  logic        busy_a, done_a, ack_err_a, clk_a, oe_a;
  logic        busy_b, done_b, ack_err_b, clk_b, oe_b;
  logic        dio_in_a, dio_in_b;

  always #5 clk_50M = ~clk_50M;

  // Device model / decoder state, index 0 = instance A, 1 = instance B.
  logic       pull [2] = '{1'b0, 1'b0};
  logic       prev_c [2] = '{1'b1, 1'b1};
  logic       prev_l [2] = '{1'b1, 1'b1};
  logic       prev_o [2] = '{1'b0, 1'b0};
  logic       busy_prev [2] = '{1'b0, 1'b0};
  logic [7:0] shreg [2];
  int         bitcnt [2] = '{0, 0};
  int         cap_n [2] = '{0, 0};
  int         starts [2] = '{0, 0};
  int         stops [2] = '{0, 0};
  int         since [2] = '{0, 0};
  int         glitches [2] = '{0, 0};
  int         nack_abs [2] = '{-1, -1};
  logic [7:0] cap [2][256];
  logic       cur_c, cur_l;

  wire [1:0] bus_clk = {clk_b, clk_a};
  wire [1:0] bus_oe  = {oe_b, oe_a};
  wire [1:0] busy_v  = {busy_b, busy_a};
  wire [1:0] div_odd = 2'b00;
  int        div [2] = '{4, 2};

  assign dio_in_a = ~(oe_a | pull[0]);
  assign dio_in_b = ~(oe_b | pull[1]);

  tm1637_display_ctrl #(.CLK_DIV(4), .NUM_DIGITS(4)) dut_a (
    .clk_50M(clk_50M), .rst_n(rst_n), .update(update_a), .digits(digits_a),
    .brightness(brightness), .display_on(display_on), .busy(busy_a),
    .done(done_a), .ack_err(ack_err_a), .tm1637_clk(clk_a),
    .tm1637_dio_oe(oe_a), .tm1637_dio_in(dio_in_a)
  );

  tm1637_display_ctrl #(.CLK_DIV(2), .NUM_DIGITS(1)) dut_b (
    .clk_50M(clk_50M), .rst_n(rst_n), .update(update_b), .digits(digits_b),
    .brightness(brightness), .display_on(display_on), .busy(busy_b),
    .done(done_b), .ack_err(ack_err_b), .tm1637_clk(clk_b),
    .tm1637_dio_oe(oe_b), .tm1637_dio_in(dio_in_b)
  );

  // Bus decoder sampled mid-cycle so simultaneous CLK/DIO register updates
  // are seen together. START/STOP = DIO edge while CLK stays high; bits are
  // taken on CLK rise, LSB first. The model pulls DIO for the ACK from the
  // falling edge after the 8th bit until the next falling edge.
  always @(negedge clk_50M) begin
    for (int i = 0; i < 2; i++) begin
      cur_c = bus_clk[i];
      cur_l = ~(bus_oe[i] | pull[i]);
      if (!rst_n) begin
        pull[i] = 1'b0;
      end else if (prev_c[i] && cur_c && prev_l[i] && !cur_l) begin
        bitcnt[i] = 0;
        starts[i]++;
      end else if (prev_c[i] && cur_c && !prev_l[i] && cur_l) begin
        stops[i]++;
      end else if (!prev_c[i] && cur_c) begin
        if (bitcnt[i] < 8) begin
          shreg[i] = {cur_l, shreg[i][7:1]};
          bitcnt[i]++;
          if (bitcnt[i] == 8 && cap_n[i] < 256) begin
            cap[i][cap_n[i]] = shreg[i];
            cap_n[i]++;
          end
        end else begin
          bitcnt[i] = 0;
        end
      end else if (prev_c[i] && !cur_c) begin
        if (pull[i]) pull[i] = 1'b0;
        else if (bitcnt[i] == 8) pull[i] = ((cap_n[i] - 1) != nack_abs[i]);
      end
      if (busy_v[i] && !busy_prev[i]) since[i] = 0;
      else if (busy_v[i]) since[i]++;
      if (busy_v[i] && ((since[i] % div[i]) != 0) &&
          ((cur_c != prev_c[i]) || (bus_oe[i] != prev_o[i]) || div_odd[i]))
        glitches[i]++;
      prev_c[i]    = cur_c;
      prev_l[i]    = ~(bus_oe[i] | pull[i]);
      prev_o[i]    = bus_oe[i];
      busy_prev[i] = busy_v[i];
    end
  end

  typedef struct {
    logic [31:0] digits;
    logic [2:0]  bright;
    logic        on;
    int          nack;
    logic [55:0] stream;
    logic        ack_err;
  } vec_t;

  vec_t vecs [6];
  int   vec_count = 0;
  int   miscompares = 0;
  int   lat;
  logic busy_rise, busy_at_done, ack_at_done, ack_hold, done_after;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic waitDoneA(input int limit, output int n);
    n = 0;
    while (!done_a && n < limit) begin
      @(posedge clk_50M);
      #1;
      n++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    @(negedge clk_50M);
    digits_a    = v.digits;
    brightness  = v.bright;
    display_on  = v.on;
    nack_abs[0] = (v.nack < 0) ? -1 : cap_n[0] + v.nack;
    update_a    = 1'b1;
    @(posedge clk_50M);
    #1;
    busy_rise = busy_a;
    ack_hold  = ack_err_a;
    update_a  = 1'b0;
    waitDoneA(3000, n);
    lat          = n;
    busy_at_done = busy_a;
    ack_at_done  = ack_err_a;
    @(posedge clk_50M);
    #1;
    done_after = done_a;
  endtask

  task automatic checkFrame(input vec_t v, input int b, input int st, input int sp);
    checkOutput("busy_rise", busy_rise, 1);
    checkOutput("done_latency", lat, 141 * 4 + 1);
    checkOutput("busy_at_done", busy_at_done, 0);
    checkOutput("ack_err", ack_at_done, v.ack_err);
    checkOutput("done_width", done_after, 0);
    checkOutput("byte_count", cap_n[0] - b, 7);
    for (int k = 0; k < 7; k++)
      checkOutput($sformatf("byte%0d", k), cap[0][b + k], v.stream[8*(6-k) +: 8]);
    checkOutput("starts", starts[0] - st, 3);
    checkOutput("stops", stops[0] - sp, 3);
  endtask

  initial begin
    int b, st, sp, n;
    logic [111:0] pend_stream;
    vecs[0] = '{32'h4F5B0630, 3'd7, 1'b1, -1, 56'h40C030065B4F8F, 1'b0};
    vecs[1] = '{32'h4F5B0630, 3'd7, 1'b1,  2, 56'h40C030065B4F8F, 1'b1};
    vecs[2] = '{32'h4F5B0630, 3'd7, 1'b1, -1, 56'h40C030065B4F8F, 1'b0};
    vecs[3] = '{32'h12345678, 3'd3, 1'b0, -1, 56'h40C07856341283, 1'b0};
    vecs[4] = '{32'h00000000, 3'd0, 1'b1, -1, 56'h40C00000000088, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 3'd5, 1'b1,  6, 56'h40C0FFFFFFFF8D, 1'b1};

    rst_n = 1'b0; update_a = 1'b0; update_b = 1'b0;
    digits_a = '0; digits_b = '0; brightness = '0; display_on = 1'b0;
    repeat (3) @(negedge clk_50M);
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_done", done_a, 0);
    checkOutput("reset_ack_err", ack_err_a, 0);
    checkOutput("reset_clk", clk_a, 1);
    checkOutput("reset_dio_oe", oe_a, 0);
    checkOutput("reset_busy_b", busy_b, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50M);

    $display("[TB] table vectors");
    for (int v = 0; v < 6; v++) begin
      b = cap_n[0]; st = starts[0]; sp = stops[0];
      applyStimulus(vecs[v]);
      checkOutput("ack_err_hold", ack_hold, (v == 0) ? 1'b0 : vecs[v-1].ack_err);
      checkFrame(vecs[v], b, st, sp);
    end

    $display("[TB] merged updates during a frame");
    b = cap_n[0]; st = starts[0];
    nack_abs[0] = -1;
    @(negedge clk_50M);
    digits_a = 32'h4F5B0630; brightness = 3'd7; display_on = 1'b1; update_a = 1'b1;
    @(negedge clk_50M);
    update_a = 1'b0;
    repeat (100) @(negedge clk_50M);
    digits_a = 32'h3F3F3F3F;
    for (int p = 0; p < 3; p++) begin
      update_a = 1'b1;
      @(negedge clk_50M);
      update_a = 1'b0;
      repeat (20) @(negedge clk_50M);
    end
    waitDoneA(3000, n);
    checkOutput("pend_first_done", done_a, 1);
    checkOutput("pend_busy_gap", busy_a, 1);
    @(posedge clk_50M);
    #1;
    waitDoneA(3000, n);
    checkOutput("pend_second_done", done_a, 1);
    checkOutput("pend_busy_end", busy_a, 0);
    repeat (800) @(negedge clk_50M);
    checkOutput("pend_byte_count", cap_n[0] - b, 14);
    checkOutput("pend_starts", starts[0] - st, 6);
    checkOutput("pend_idle", busy_a, 0);
    pend_stream = 112'h40C030065B4F8F_40C03F3F3F3F8F;
    for (int k = 0; k < 14; k++)
      checkOutput($sformatf("pend_byte%0d", k), cap[0][b + k], pend_stream[8*(13-k) +: 8]);

    $display("[TB] reset mid-byte");
    @(negedge clk_50M);
    update_a = 1'b1;
    @(negedge clk_50M);
    update_a = 1'b0;
    repeat (120) @(negedge clk_50M);
    checkOutput("pre_rst_clk", clk_a, 0);
    checkOutput("pre_rst_dio_oe", oe_a, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_clk", clk_a, 1);
    checkOutput("rst_dio_oe", oe_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    b = cap_n[0]; st = starts[0]; sp = stops[0];
    applyStimulus(vecs[0]);
    checkFrame(vecs[0], b, st, sp);

    $display("[TB] single digit, CLK_DIV=2");
    b = cap_n[1]; st = starts[1]; sp = stops[1];
    @(negedge clk_50M);
    digits_b = 8'hA5; brightness = 3'd2; display_on = 1'b1; update_b = 1'b1;
    @(posedge clk_50M);
    #1;
    checkOutput("b_busy_rise", busy_b, 1);
    update_b = 1'b0;
    n = 0;
    while (!done_b && n < 3000) begin
      @(posedge clk_50M);
      #1;
      n++;
    end
    // 3 STARTs (6) + 4 bytes (72) + 3 STOPs (9) = 87 ticks of 2 cycles.
    checkOutput("b_done_latency", n, 87 * 2 + 1);
    checkOutput("b_busy_at_done", busy_b, 0);
    checkOutput("b_byte_count", cap_n[1] - b, 4);
    checkOutput("b_byte0", cap[1][b], 8'h40);
    checkOutput("b_byte1", cap[1][b + 1], 8'hC0);
    checkOutput("b_byte2", cap[1][b + 2], 8'hA5);
    checkOutput("b_byte3", cap[1][b + 3], 8'h8A);
    checkOutput("b_starts", starts[1] - st, 3);
    checkOutput("b_stops", stops[1] - sp, 3);
    checkOutput("b_glitches", glitches[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
